// File: rtl/alu_pkg.sv
// Shared definitions for the ALU requester slice.
// Op codes, error result constant, requester state and error predicate.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_MUL = 4'h2;
    localparam logic [3:0] ALU_DIV = 4'h3;

    localparam logic [7:0] ALU_ERR_RESULT = 8'hAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } req_state_e;

    // Error is judged from the command itself: 0xAC is also a legal
    // arithmetic result, so the ALU output cannot be used for this.
    function automatic logic is_err(input logic [31:0] op,
                                    input logic        b_zero);
        return (op > 32'(ALU_DIV)) ||
               ((op == 32'(ALU_DIV)) && b_zero);
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous command FIFO for the ALU requester.
// Ports: clock_i/reset_i, push_i+wdata_i, pop_i, rdata_o (head), full_o, empty_o.
module alu_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                mem_q[wptr_q[AW-1:0]] <= wdata_i;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_requester.sv
// Initiator for the ALU: buffers tagged commands, issues one at a time,
// returns tagged responses.
// Ports: clock/reset; cmd_* in (valid/ready); alu_a/alu_b/alu_op_code out,
// alu_result/alu_carry_out in; rsp_* out (valid/ready); busy, rsp_count.
import alu_pkg::*;

module alu_requester #(
    parameter int DATA_W      = 8,
    parameter int OP_W        = 4,
    parameter int TAG_W       = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op_code,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_carry,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              busy,
    output logic [15:0]       rsp_count
);

    localparam int CW    = 2 * DATA_W + OP_W + TAG_W;
    localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(ALU_LATENCY);

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              capture;
    logic              rsp_hs;
    logic [CW-1:0]     head;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [OP_W-1:0]   head_op;
    logic [TAG_W-1:0]  head_tag;

    req_state_e state_q, state_d;

    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_carry_q, rsp_carry_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_err_q, rsp_err_d;
    logic [15:0]       rsp_count_q, rsp_count_d;

    assign push = cmd_valid && cmd_ready;
    assign {head_tag, head_op, head_a, head_b} = head;

    alu_req_fifo #(
        .WIDTH (CW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (push),
        .wdata_i ({cmd_tag, cmd_op, cmd_a, cmd_b}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = WAIT;
            WAIT:    if (wait_cnt_q == '0) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = !fifo_full;
        rsp_valid = 1'b0;
        busy      = !fifo_empty;
        pop       = 1'b0;
        capture   = 1'b0;
        rsp_hs    = 1'b0;
        unique case (state_q)
            IDLE: pop = !fifo_empty;
            WAIT: begin
                busy    = 1'b1;
                capture = (wait_cnt_q == '0);
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                rsp_hs    = rsp_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        tag_d        = tag_q;
        err_d        = err_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_tag_d    = rsp_tag_q;
        rsp_err_d    = rsp_err_q;
        rsp_count_d  = rsp_count_q;
        if (pop) begin
            alu_a_d    = head_a;
            alu_b_d    = head_b;
            alu_op_d   = head_op;
            tag_d      = head_tag;
            err_d      = is_err(32'(head_op), head_b == '0);
            wait_cnt_d = LAT;
        end else if (state_q == WAIT && wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - 1'b1;
        end
        if (capture) begin
            rsp_result_d = alu_result;
            rsp_carry_d  = alu_carry_out;
            rsp_tag_d    = tag_q;
            rsp_err_d    = err_q;
        end
        if (rsp_hs) begin
            rsp_count_d = rsp_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
            rsp_count_q  <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
            rsp_count_q  <= rsp_count_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op_code = alu_op_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_carry   = rsp_carry_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_count   = rsp_count_q;

endmodule
